// File: rtl/avalon_s_pkg.sv
// Shared definitions for the Avalon-MM slave-side arbiter slice.
//   HOST_*      : fixed host slot indices used by the SoC bus fabric
//   arb_state_e : arbiter lock state
package avalon_s_pkg;

    localparam int unsigned HOST_DEBUG = 0;
    localparam int unsigned HOST_DBUS  = 1;
    localparam int unsigned HOST_IBUS  = 2;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

endpackage

// File: rtl/rr_priority_select.sv
// One-hot select of the first set request bit at or above a pointer,
// wrapping modulo NH. Purely combinational.
//   req_i : request vector
//   ptr_i : search start index (0..NH-1)
//   gnt_o : one-hot winner, '0 when no request is set
module rr_priority_select #(
    parameter  int unsigned NH  = 3,
    localparam int unsigned PW  = (NH > 1) ? $clog2(NH) : 1
) (
    input  logic [NH-1:0] req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [NH-1:0] gnt_o
);

    localparam int unsigned PW1  = PW + 1;
    localparam logic [PW:0] NH_W = PW1'(NH);

    logic          found;
    logic [PW:0]   pos;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < NH; k++) begin
            // One extra bit holds ptr+k before the modulo-NH fold.
            pos = {1'b0, ptr_i} + PW1'(k);
            if (pos >= NH_W) begin
                pos = pos - NH_W;
            end
            if (!found && req_i[pos[PW-1:0]]) begin
                gnt_o[pos[PW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/avalon_s_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave device among NH hosts.
// The grant is combinational in IDLE and frozen on the owner while the
// device stalls; priority rotates past the winner once the transfer is
// accepted (or the owner abandons it).
//   hosts_avn_*            : per-host command inputs, readdata/waitrequest out
//   device_avn_*           : forwarded command to the device, readdata/wait in
//   grant                  : one-hot current grant (debug / perf counters)
module avalon_s_arbiter #(
    parameter int unsigned NH = 3,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NH-1:0]             hosts_avn_read,
    input  logic [NH-1:0]             hosts_avn_write,
    input  logic [NH-1:0][AW-1:0]     hosts_avn_address,
    input  logic [NH-1:0][DW/8-1:0]   hosts_avn_byte_enable,
    input  logic [NH-1:0][DW-1:0]     hosts_avn_writedata,
    output logic [NH-1:0][DW-1:0]     hosts_avn_readdata,
    output logic [NH-1:0]             hosts_avn_waitrequest,
    output logic                      device_avn_read,
    output logic                      device_avn_write,
    output logic [AW-1:0]             device_avn_address,
    output logic [DW/8-1:0]           device_avn_byte_enable,
    output logic [DW-1:0]             device_avn_writedata,
    input  logic [DW-1:0]             device_avn_readdata,
    input  logic                      device_avn_waitrequest,
    output logic [NH-1:0]             grant
);

    import avalon_s_pkg::*;

    localparam int unsigned   PW   = (NH > 1) ? $clog2(NH) : 1;
    localparam logic [PW-1:0] LAST = PW'(NH - 1);

    arb_state_e    state_q;
    logic [PW-1:0] owner_q;
    logic [PW-1:0] rr_ptr_q;

    logic [NH-1:0] req;
    logic [NH-1:0] rr_gnt;
    logic [NH-1:0] grant_sel;
    logic [PW-1:0] grant_idx;
    logic          grant_req;

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
        return (idx == LAST) ? '0 : idx + 1'b1;
    endfunction

    assign req = hosts_avn_read | hosts_avn_write;

    rr_priority_select #(.NH(NH)) u_select (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (rr_gnt)
    );

    // Nothing is granted while reset is asserted, even mid-lock.
    always_comb begin
        grant_sel = '0;
        if (!rst) begin
            if (state_q == LOCKED) begin
                grant_sel[owner_q] = 1'b1;
            end else begin
                grant_sel = rr_gnt;
            end
        end
    end

    assign grant     = grant_sel;
    assign grant_req = |(grant_sel & req);

    // When the owner drops req while locked its read/write are both low,
    // so forwarding them unchanged already yields an idle device cycle.
    always_comb begin
        device_avn_read        = 1'b0;
        device_avn_write       = 1'b0;
        device_avn_address     = '0;
        device_avn_byte_enable = '0;
        device_avn_writedata   = '0;
        hosts_avn_waitrequest  = '1;
        grant_idx              = '0;
        for (int unsigned i = 0; i < NH; i++) begin
            if (grant_sel[i]) begin
                device_avn_read          = hosts_avn_read[i];
                device_avn_write         = hosts_avn_write[i];
                device_avn_address       = hosts_avn_address[i];
                device_avn_byte_enable   = hosts_avn_byte_enable[i];
                device_avn_writedata     = hosts_avn_writedata[i];
                hosts_avn_waitrequest[i] = device_avn_waitrequest;
                grant_idx                = PW'(i);
            end
        end
    end

    assign hosts_avn_readdata = {NH{device_avn_readdata}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_req) begin
                        if (!device_avn_waitrequest) begin
                            rr_ptr_q <= ptr_after(grant_idx);
                        end else begin
                            state_q <= LOCKED;
                            owner_q <= grant_idx;
                        end
                    end
                end
                LOCKED: begin
                    // Completion and owner abandonment both release the lock.
                    if (!grant_req || !device_avn_waitrequest) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= ptr_after(owner_q);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_s_arbiter.sv
module tb_avalon_s_arbiter;

    localparam int unsigned NH = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NH-1:0]           h_rd, h_wr;
    logic [NH-1:0][AW-1:0]   h_addr;
    logic [NH-1:0][DW/8-1:0] h_be;
    logic [NH-1:0][DW-1:0]   h_wdata;
    logic [NH-1:0][DW-1:0]   h_rdata;
    logic [NH-1:0]           h_wait;
    logic                    d_rd, d_wr;
    logic [AW-1:0]           d_addr;
    logic [DW/8-1:0]         d_be;
    logic [DW-1:0]           d_wdata;
    logic [DW-1:0]           d_rdata;
    logic                    d_wait;
    logic [NH-1:0]           grant;

    int total = 0;
    int bad   = 0;

    // Reference model: who holds the device, where the round-robin search starts.
    bit          m_locked = 1'b0;
    int          m_owner  = 0;
    int          m_ptr    = 0;
    logic [NH-1:0] sg;

    avalon_s_arbiter #(.NH(NH), .AW(AW), .DW(DW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .hosts_avn_read         (h_rd),
        .hosts_avn_write        (h_wr),
        .hosts_avn_address      (h_addr),
        .hosts_avn_byte_enable  (h_be),
        .hosts_avn_writedata    (h_wdata),
        .hosts_avn_readdata     (h_rdata),
        .hosts_avn_waitrequest  (h_wait),
        .device_avn_read        (d_rd),
        .device_avn_write       (d_wr),
        .device_avn_address     (d_addr),
        .device_avn_byte_enable (d_be),
        .device_avn_writedata   (d_wdata),
        .device_avn_readdata    (d_rdata),
        .device_avn_waitrequest (d_wait),
        .grant                  (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge against the model, then advance
    // the model with the inputs seen at the posedge.
    task automatic cycle();
        int            g;
        logic [NH-1:0] req;
        logic [NH-1:0] eg;
        logic [NH-1:0] ew;
        @(negedge clk);
        req = h_rd | h_wr;
        g   = -1;
        if (!rst) begin
            if (m_locked) begin
                g = m_owner;
            end else begin
                for (int k = 0; k < NH; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NH;
                    if (req[idx]) begin
                        g = idx;
                        break;
                    end
                end
            end
        end
        eg = '0;
        ew = '1;
        if (g >= 0) begin
            eg[g] = 1'b1;
            ew[g] = d_wait;
        end
        chk("grant", 64'(grant), 64'(eg));
        chk("hwait", 64'(h_wait), 64'(ew));
        chk("dread", 64'(d_rd), (g >= 0) ? 64'(h_rd[g]) : 64'd0);
        chk("dwrite", 64'(d_wr), (g >= 0) ? 64'(h_wr[g]) : 64'd0);
        chk("daddr", 64'(d_addr), (g >= 0) ? 64'(h_addr[g]) : 64'd0);
        chk("dbe", 64'(d_be), (g >= 0) ? 64'(h_be[g]) : 64'd0);
        chk("dwdata", 64'(d_wdata), (g >= 0) ? 64'(h_wdata[g]) : 64'd0);
        for (int i = 0; i < NH; i++) begin
            chk("rdata", 64'(h_rdata[i]), 64'(d_rdata));
        end
        sg = grant;
        @(posedge clk);
        if (rst) begin
            m_locked = 1'b0;
            m_owner  = 0;
            m_ptr    = 0;
        end else if (g >= 0) begin
            if (!req[g] || !d_wait) begin
                m_locked = 1'b0;
                m_ptr    = (g + 1) % NH;
            end else begin
                m_locked = 1'b1;
                m_owner  = g;
            end
        end
        #1;
    endtask

    task automatic drive(input logic [NH-1:0] rd, input logic [NH-1:0] wr, input logic w);
        h_rd   = rd;
        h_wr   = wr;
        d_wait = w;
    endtask

    initial begin
        rst     = 1'b1;
        h_rd    = '0;
        h_wr    = '0;
        d_wait  = 1'b0;
        d_rdata = 32'h1234_5678;
        for (int i = 0; i < NH; i++) begin
            h_addr[i]  = 32'h1000_0000 + 32'(i * 16);
            h_be[i]    = 4'hF;
            h_wdata[i] = 32'hA000_0000 + 32'(i);
        end
        // Reset: all hosts stalled, nothing forwarded.
        drive(3'b111, 3'b000, 1'b0);
        cycle();
        chk("rst_grant", 64'(sg), 64'd0);
        rst = 1'b0;
        drive(3'b000, 3'b000, 1'b0);
        cycle();
        chk("idle_grant", 64'(sg), 64'd0);

        // Single host: host1 reads, accepted immediately.
        h_addr[1] = 32'h8000_0010;
        drive(3'b010, 3'b000, 1'b0);
        cycle();
        chk("single_grant", 64'(sg), 64'b010);
        // Pointer now at 2; lone host1 still wins without a dead cycle.
        cycle();
        chk("wrap_grant", 64'(sg), 64'b010);
        // Pointer at 2 again: everyone requesting -> host2 first.
        drive(3'b111, 3'b000, 1'b0);
        cycle();
        chk("ptr2_grant", 64'(sg), 64'b100);

        // Contention from reset.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("cont0", 64'(sg), 64'b001);
        cycle();
        chk("cont1", 64'(sg), 64'b010);
        cycle();
        chk("cont2", 64'(sg), 64'b100);
        cycle();
        chk("cont3", 64'(sg), 64'b001);

        // Lock: host2 writes, device stalls 3 cycles, host0 waits.
        h_wdata[2] = 32'hDEAD_BEEF;
        drive(3'b001, 3'b100, 1'b1);
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("lock_grant", 64'(sg), 64'b100);
        end
        d_wait = 1'b0;
        cycle();
        chk("lock_done", 64'(sg), 64'b100);
        drive(3'b001, 3'b000, 1'b0);
        cycle();
        chk("lock_next", 64'(sg), 64'b001);

        // Abort: host1 locks, then drops its write.
        drive(3'b000, 3'b010, 1'b1);
        cycle();
        chk("abort_lock", 64'(sg), 64'b010);
        drive(3'b000, 3'b000, 1'b1);
        cycle();
        chk("abort_grant", 64'(sg), 64'b010);
        drive(3'b001, 3'b000, 1'b0);
        cycle();
        chk("abort_next", 64'(sg), 64'b001);

        // Reset during a host1 stall.
        drive(3'b010, 3'b000, 1'b1);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        chk("rstlock_grant", 64'(sg), 64'd0);
        rst = 1'b0;
        drive(3'b111, 3'b000, 1'b0);
        cycle();
        chk("rstlock_after", 64'(sg), 64'b001);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NH; i++) begin
                h_rd[i]    = ($urandom_range(0, 2) == 0);
                h_wr[i]    = ($urandom_range(0, 2) == 0);
                h_addr[i]  = $urandom;
                h_be[i]    = 4'($urandom);
                h_wdata[i] = $urandom;
            end
            d_wait  = ($urandom_range(0, 1) == 1);
            d_rdata = $urandom;
            rst     = ($urandom_range(0, 49) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
